// File: rtl/coin_pkg.sv
// Shared definitions for the coin transaction datapath.
// Step codes, table size and the hash unit's state encoding.
package coin_pkg;

  localparam logic [2:0] STEP_VERIFY = 3'b001;
  localparam logic [2:0] STEP_HASH   = 3'b010;
  localparam logic [2:0] STEP_CHECK  = 3'b011;
  localparam logic [2:0] STEP_STORE  = 3'b100;

  localparam int TABLE_BYTES = 36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hash_state_e;

endpackage

// File: rtl/key_hash_unit_hash_round.sv
// One hash fold: rotl1(h ^ tbyte) + key, modulo 256.
// Ports: h, tbyte, key in (8); h_next out (8). Purely combinational.
module hash_round (
  input  logic [7:0] h,
  input  logic [7:0] tbyte,
  input  logic [7:0] key,
  output logic [7:0] h_next
);

  logic [7:0] x;

  always_comb begin
    x      = h ^ tbyte;
    h_next = {x[6:0], x[7]} + key;
  end

endmodule

// File: rtl/key_hash_unit.sv
// Hash-step responder: folds the player key through the random table.
// Ports: clock, reset, step, input_key, random_table, expected_hash in;
// done_step, hash_out, hash_match, busy out.
import coin_pkg::*;

module key_hash_unit #(
  parameter int         TABLE_BYTES = coin_pkg::TABLE_BYTES,
  parameter logic [2:0] HASH_STEP   = STEP_HASH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2:0]               step,
  input  logic [7:0]               input_key,
  input  logic [8*TABLE_BYTES-1:0] random_table,
  input  logic [7:0]               expected_hash,
  output logic                     done_step,
  output logic [7:0]               hash_out,
  output logic                     hash_match,
  output logic                     busy
);

  hash_state_e state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  h_q, h_d;
  logic [5:0]  round_q, round_d;

  logic        hit;
  logic        last;
  logic [7:0]  tbyte;
  logic [7:0]  h_next;

  assign hit   = (step == HASH_STEP);
  assign last  = (round_q == 6'(TABLE_BYTES - 1));
  assign tbyte = random_table[{round_q, 3'b000} +: 8];

  hash_round u_round (
    .h      (h_q),
    .tbyte  (tbyte),
    .key    (key_q),
    .h_next (h_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= 8'h00;
      h_q     <= 8'h00;
      round_q <= 6'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      h_q     <= h_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (hit) state_d = ST_RUN;
      ST_RUN: begin
        if (!hit)      state_d = ST_IDLE;
        else if (last) state_d = ST_DONE;
      end
      ST_DONE: if (!hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // An abort leaves h_q holding its partial value.
  always_comb begin
    key_d   = key_q;
    h_d     = h_q;
    round_d = round_q;
    if (state_q == ST_IDLE && hit) begin
      key_d   = input_key;
      h_d     = input_key;
      round_d = 6'd0;
    end else if (state_q == ST_RUN && hit) begin
      h_d     = h_next;
      round_d = last ? round_q : round_q + 6'd1;
    end
  end

  always_comb begin
    done_step  = (state_q == ST_DONE);
    busy       = (state_q == ST_RUN);
    hash_out   = h_q;
    hash_match = done_step & (h_q == expected_hash);
  end

endmodule

// File: tb/tb_key_hash_unit.sv
// Directed and random checks of key_hash_unit.
// Golden model for random vectors uses hash_round.
module tb_key_hash_unit;

  localparam int TB = 36;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    step;
  logic [7:0]    input_key;
  logic [8*TB-1:0] random_table;
  logic [7:0]    expected_hash;
  logic          done_step;
  logic [7:0]    hash_out;
  logic          hash_match;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_h, m_t, m_k, m_out;

  always #5 clock = ~clock;

  key_hash_unit #(.TABLE_BYTES(TB), .HASH_STEP(3'b010)) dut (
    .clock         (clock),
    .reset         (reset),
    .step          (step),
    .input_key     (input_key),
    .random_table  (random_table),
    .expected_hash (expected_hash),
    .done_step     (done_step),
    .hash_out      (hash_out),
    .hash_match    (hash_match),
    .busy          (busy)
  );

  hash_round u_model (
    .h      (m_h),
    .tbyte  (m_t),
    .key    (m_k),
    .h_next (m_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model(input logic [7:0] key,
                       input logic [8*TB-1:0] tbl,
                       output logic [7:0] res);
    m_h = key;
    m_k = key;
    for (int r = 0; r < TB; r++) begin
      m_t = tbl[8*r +: 8];
      #1;
      m_h = m_out;
    end
    res = m_h;
  endtask

  // Raise step and run until done_step; edges counts E0 onward.
  task automatic run_hash(input logic [7:0] key, input bit toggle,
                          output int edges, output int bcyc);
    step = 3'b010;
    input_key = key;
    edges = 0;
    bcyc = 0;
    do begin
      tick();
      edges++;
      if (busy) bcyc++;
      if (toggle) input_key = 8'($urandom);
    end while (!done_step && edges < 80);
  endtask

  task automatic leave_step();
    step = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step = 3'b000;
    input_key = 8'h00;
    random_table = '0;
    expected_hash = 8'h00;
    tick();
    tick();
    n_cmp++;
    if ({done_step, busy, hash_out, hash_match} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset: done=%b busy=%b hash=%h match=%b want all 0",
               done_step, busy, hash_out, hash_match);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({done_step, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: done=%b busy=%b want 0 0",
               done_step, busy);
    end
  endtask

  task automatic test_zero_table();
    int e, b;
    random_table = '0;
    expected_hash = 8'h01;
    run_hash(8'h01, 1'b0, e, b);
    n_cmp++;
    if (e !== 37) begin
      n_bad++;
      $display("FAIL zero_latency: got %0d edges want 37", e);
    end
    n_cmp++;
    if (b !== 36) begin
      n_bad++;
      $display("FAIL zero_busy: got %0d cycles want 36", b);
    end
    n_cmp++;
    if (hash_out !== 8'h01) begin
      n_bad++;
      $display("FAIL zero_hash: got %h want 01", hash_out);
    end
    n_cmp++;
    if (hash_match !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_match: got %b want 1", hash_match);
    end
    leave_step();
  endtask

  task automatic test_ones_table();
    int e, b;
    random_table = '1;
    expected_hash = 8'h5A;
    run_hash(8'h00, 1'b0, e, b);
    n_cmp++;
    if (done_step !== 1'b1 || hash_out !== 8'h00) begin
      n_bad++;
      $display("FAIL ones_hash: done=%b hash=%h want 1 00",
               done_step, hash_out);
    end
    n_cmp++;
    if (hash_match !== 1'b0) begin
      n_bad++;
      $display("FAIL ones_nomatch: got %b want 0", hash_match);
    end
    expected_hash = 8'h00;
    #1;
    n_cmp++;
    if (hash_match !== 1'b1) begin
      n_bad++;
      $display("FAIL ones_match_follow: got %b want 1", hash_match);
    end
    leave_step();
  endtask

  task automatic test_abort();
    int e, b;
    bit seen;
    random_table = '0;
    expected_hash = 8'h01;
    step = 3'b010;
    input_key = 8'h01;
    tick();
    repeat (10) tick();
    step = 3'b001;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done_step !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b done=%b want 0 0",
               busy, done_step);
    end
    n_cmp++;
    if (hash_out !== 8'h03) begin
      n_bad++;
      $display("FAIL abort_partial: got %h want 03", hash_out);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done_step) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_done: got done=1 want never");
    end
    run_hash(8'h01, 1'b0, e, b);
    n_cmp++;
    if (e !== 37 || hash_out !== 8'h01) begin
      n_bad++;
      $display("FAIL abort_rerun: edges=%0d hash=%h want 37 01",
               e, hash_out);
    end
  endtask

  task automatic test_hold_release();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_step !== 1'b1 || hash_out !== 8'h01) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    end
    step = 3'b011;
    tick();
    n_cmp++;
    if (done_step !== 1'b0) begin
      n_bad++;
      $display("FAIL release_done: got %b want 0", done_step);
    end
    bad = 0;
    repeat (5) begin
      tick();
      if (busy || done_step) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL release_norestart: got %0d active cycles want 0", bad);
    end
    leave_step();
  endtask

  task automatic test_reset_mid_run();
    int e, b;
    random_table = '0;
    expected_hash = 8'h01;
    step = 3'b010;
    input_key = 8'h01;
    tick();
    repeat (18) tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({done_step, busy, hash_out, hash_match} !== 11'd0) begin
      n_bad++;
      $display("FAIL midrst_outs: done=%b busy=%b hash=%h match=%b want 0",
               done_step, busy, hash_out, hash_match);
    end
    reset = 1'b0;
    run_hash(8'h01, 1'b0, e, b);
    n_cmp++;
    if (e !== 37 || hash_out !== 8'h01 || hash_match !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_rerun: edges=%0d hash=%h match=%b want 37 01 1",
               e, hash_out, hash_match);
    end
    leave_step();
  endtask

  task automatic test_random();
    int e, b;
    logic [7:0] key, exp_h;
    logic [8*TB-1:0] tbl;
    for (int i = 0; i < 200; i++) begin
      key = 8'($urandom);
      for (int w = 0; w < 9; w++) tbl[32*w +: 32] = $urandom;
      model(key, tbl, exp_h);
      random_table = tbl;
      expected_hash = (i % 2 == 0) ? exp_h : exp_h ^ 8'h10;
      run_hash(key, 1'b1, e, b);
      n_cmp++;
      if (e !== 37 || hash_out !== exp_h) begin
        n_bad++;
        $display("FAIL rand_hash[%0d]: edges=%0d hash=%h want 37 %h",
                 i, e, hash_out, exp_h);
      end
      n_cmp++;
      if (hash_match !== (i % 2 == 0)) begin
        n_bad++;
        $display("FAIL rand_match[%0d]: got %b want %b",
                 i, hash_match, (i % 2 == 0));
      end
      leave_step();
    end
  endtask

  initial begin
    test_reset();
    test_zero_table();
    test_ones_table();
    test_abort();
    test_hold_release();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
